// File: rtl/buraq_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   hazard_state_e      : controller FSM states
//   DIV_LATENCY_DEFAULT : default EX occupancy of a DIV/REM instruction
//   hazard_ctrl_t       : the six pipeline stall/flush enables as one bundle
package buraq_hazard_pkg;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        LOAD_BUBBLE = 2'd1,
        DIV_WAIT    = 2'd2,
        DIV_RELEASE = 2'd3
    } hazard_state_e;

    localparam int DIV_LATENCY_DEFAULT = 34;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_flush;
    } hazard_ctrl_t;

    // Bundle order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush
    localparam hazard_ctrl_t CTRL_NONE   = hazard_ctrl_t'(6'b000000);
    localparam hazard_ctrl_t CTRL_LOAD   = hazard_ctrl_t'(6'b110010);
    localparam hazard_ctrl_t CTRL_DIV    = hazard_ctrl_t'(6'b110101);
    localparam hazard_ctrl_t CTRL_BRANCH = hazard_ctrl_t'(6'b001010);

endpackage

// File: rtl/hazard_perf_counter.sv
// 32-bit enabled event counter, wraps at 2^32, async active-high reset.
// Ports:
//   i_clk   : clock
//   i_rst   : async active-high reset (clears count)
//   i_en    : count this cycle
//   o_count : current count
module hazard_perf_counter (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    output logic [31:0] o_count
);

    logic [31:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)     r_count <= '0;
        else if (i_en) r_count <= r_count + 32'd1;
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller for the 5-stage core (ID/EX boundary).
// Resolves what forwarding cannot: load-use bubbles, multi-cycle DIV/REM
// occupancy of EX, and taken-branch redirect flushes.
// Ports:
//   clk, reset                 : clock, async active-high reset
//   ID_RS1/ID_RS2, ID_Uses_RS* : source operands of the ID instruction
//   EX_RD, EX_Reg_File_EN      : destination of the EX instruction
//   EX_Mem_Read_EN             : EX instruction is a load
//   EX_Div_Start               : EX instruction is DIV/DIVU/REM/REMU
//   EX_Branch_Taken            : EX redirect
//   PC_Stall .. EX_MEM_Flush   : pipeline register stall/flush enables
//   Div_Busy, Div_Result_Valid : divider status
// Optional (macro HAZARD_PERF_CNT_EN): Load_Stall_Count, Div_Stall_Count,
// Flush_Count, 32-bit wrapping event counters.
module hazard_control_unit
    import buraq_hazard_pkg::*;
#(
    parameter int RegAddrWidth = 5,
    parameter int DivLatency   = DIV_LATENCY_DEFAULT,
    parameter int CntWidth     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [RegAddrWidth-1:0] ID_RS1,
    input  logic [RegAddrWidth-1:0] ID_RS2,
    input  logic                    ID_Uses_RS1,
    input  logic                    ID_Uses_RS2,
    input  logic [RegAddrWidth-1:0] EX_RD,
    input  logic                    EX_Reg_File_EN,
    input  logic                    EX_Mem_Read_EN,
    input  logic                    EX_Div_Start,
    input  logic                    EX_Branch_Taken,
    output logic                    PC_Stall,
    output logic                    IF_ID_Stall,
    output logic                    IF_ID_Flush,
    output logic                    ID_EX_Stall,
    output logic                    ID_EX_Flush,
    output logic                    EX_MEM_Flush,
    output logic                    Div_Busy,
    output logic                    Div_Result_Valid
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]             Load_Stall_Count,
    output logic [31:0]             Div_Stall_Count,
    output logic [31:0]             Flush_Count
`endif
);

    generate
        if (DivLatency < 2 || DivLatency > 255 || (DivLatency - 2) >= (1 << CntWidth)) begin : g_bad_cfg
            $error("hazard_control_unit: DivLatency out of range or DivLatency-2 does not fit in CntWidth");
        end
    endgenerate

    // Counter reload: the start cycle plus DivLatency-1 wait cycles (reload..0).
    localparam logic [CntWidth-1:0] DIV_RELOAD = CntWidth'(DivLatency - 2);

    hazard_state_e       r_state;
    logic [CntWidth-1:0] r_cnt;
    // Low during reset and the first cycle after release; masks all outputs
    // and holds the FSM in RUN for that cycle.
    logic                r_active;

    hazard_state_e       w_next;
    logic [CntWidth-1:0] w_cnt_next;
    hazard_ctrl_t        w_ctrl;
    logic                w_busy;
    logic                w_valid;
    logic                w_load_evt;
    logic                w_flush_evt;
    logic                w_load_use;

    // x0 is hardwired zero, so it never produces a hazard.
    assign w_load_use = EX_Mem_Read_EN & EX_Reg_File_EN & (EX_RD != '0) &
                        ((ID_Uses_RS1 & (ID_RS1 == EX_RD)) |
                         (ID_Uses_RS2 & (ID_RS2 == EX_RD)));

    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        w_ctrl      = CTRL_NONE;
        w_busy      = 1'b0;
        w_valid     = 1'b0;
        w_load_evt  = 1'b0;
        w_flush_evt = 1'b0;
        if (!r_active) begin
            w_next = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    // Redirect first: the ID instruction is wrong-path.
                    if (EX_Branch_Taken) begin
                        w_ctrl      = CTRL_BRANCH;
                        w_flush_evt = 1'b1;
                    end else if (EX_Div_Start) begin
                        w_ctrl     = CTRL_DIV;
                        w_busy     = 1'b1;
                        w_cnt_next = DIV_RELOAD;
                        w_next     = DIV_WAIT;
                    end else if (w_load_use) begin
                        w_ctrl     = CTRL_LOAD;
                        w_load_evt = 1'b1;
                        w_next     = LOAD_BUBBLE;
                    end
                end
                // EX holds the bubble; nothing to detect.
                LOAD_BUBBLE: w_next = RUN;
                DIV_WAIT: begin
                    w_ctrl = CTRL_DIV;
                    w_busy = 1'b1;
                    if (r_cnt == '0) w_next = DIV_RELEASE;
                    else             w_cnt_next = r_cnt - CntWidth'(1);
                end
                // Same DIV still in EX: its Div_Start must not retrigger.
                DIV_RELEASE: begin
                    w_valid = 1'b1;
                    w_next  = RUN;
                end
                default: w_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= RUN;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_next;
            r_active <= 1'b1;
        end
    end

    assign PC_Stall         = w_ctrl.pc_stall;
    assign IF_ID_Stall      = w_ctrl.if_id_stall;
    assign IF_ID_Flush      = w_ctrl.if_id_flush;
    assign ID_EX_Stall      = w_ctrl.id_ex_stall;
    assign ID_EX_Flush      = w_ctrl.id_ex_flush;
    assign EX_MEM_Flush     = w_ctrl.ex_mem_flush;
    assign Div_Busy         = w_busy;
    assign Div_Result_Valid = w_valid;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counter u_load_cnt (
        .i_clk(clk), .i_rst(reset), .i_en(w_load_evt),  .o_count(Load_Stall_Count)
    );
    hazard_perf_counter u_div_cnt (
        .i_clk(clk), .i_rst(reset), .i_en(w_busy),      .o_count(Div_Stall_Count)
    );
    hazard_perf_counter u_flush_cnt (
        .i_clk(clk), .i_rst(reset), .i_en(w_flush_evt), .o_count(Flush_Count)
    );
`else
    logic w_unused_evt;
    assign w_unused_evt = w_load_evt ^ w_flush_evt;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit (DivLatency = 34).
// Output vector order: {PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall,
//                       ID_EX_Flush, EX_MEM_Flush, Div_Busy, Div_Result_Valid}
module tb_hazard_control_unit;

    localparam logic [7:0] O_NONE = 8'h00;
    localparam logic [7:0] O_LOAD = 8'hC8;
    localparam logic [7:0] O_DIV  = 8'hD6;
    localparam logic [7:0] O_BR   = 8'h28;
    localparam logic [7:0] O_REL  = 8'h01;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ID_RS1, ID_RS2, EX_RD;
    logic       ID_Uses_RS1, ID_Uses_RS2, EX_Reg_File_EN, EX_Mem_Read_EN;
    logic       EX_Div_Start, EX_Branch_Taken;
    logic       PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall;
    logic       ID_EX_Flush, EX_MEM_Flush, Div_Busy, Div_Result_Valid;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] Load_Stall_Count, Div_Stall_Count, Flush_Count;
`endif
    logic [7:0] outv;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(.RegAddrWidth(5), .DivLatency(34), .CntWidth(8)) dut (
        .clk(clk), .reset(reset),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .ID_Uses_RS1(ID_Uses_RS1), .ID_Uses_RS2(ID_Uses_RS2),
        .EX_RD(EX_RD), .EX_Reg_File_EN(EX_Reg_File_EN),
        .EX_Mem_Read_EN(EX_Mem_Read_EN), .EX_Div_Start(EX_Div_Start),
        .EX_Branch_Taken(EX_Branch_Taken),
        .PC_Stall(PC_Stall), .IF_ID_Stall(IF_ID_Stall), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Stall(ID_EX_Stall), .ID_EX_Flush(ID_EX_Flush),
        .EX_MEM_Flush(EX_MEM_Flush), .Div_Busy(Div_Busy),
        .Div_Result_Valid(Div_Result_Valid)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .Load_Stall_Count(Load_Stall_Count), .Div_Stall_Count(Div_Stall_Count),
        .Flush_Count(Flush_Count)
`endif
    );

    assign outv = {PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall,
                   ID_EX_Flush, EX_MEM_Flush, Div_Busy, Div_Result_Valid};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic setin(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rf, input logic mrd, input logic dv, input logic br);
        ID_RS1 = rs1; ID_RS2 = rs2; ID_Uses_RS1 = u1; ID_Uses_RS2 = u2;
        EX_RD = rd; EX_Reg_File_EN = rf; EX_Mem_Read_EN = mrd;
        EX_Div_Start = dv; EX_Branch_Taken = br;
    endtask

    // Called at posedge+1: let inputs settle, check, move to next posedge+1.
    task automatic cyc_chk(input string tag, input logic [7:0] exp);
        #3;
        chk(tag, {24'd0, outv}, {24'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        setin(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic div_seq(input string tag);
        for (int i = 0; i < 34; i++) cyc_chk({tag, "_busy"}, O_DIV);
        cyc_chk({tag, "_rel"}, O_REL);
    endtask

    initial begin
        reset = 1'b1;
        // Load-use pattern present during reset: must be masked.
        setin(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        chk("reset_async", {24'd0, outv}, 32'd0);
        @(posedge clk); #1;
        cyc_chk("reset_hold", O_NONE);
        reset = 1'b0;
        cyc_chk("first_after_rel", O_NONE);

        // Load-use through rs1, then one bubble cycle with detection masked.
        cyc_chk("lu_rs1", O_LOAD);
        cyc_chk("lu_bubble", O_NONE);
        idle();
        cyc_chk("lu_after", O_NONE);

        // Load-use through rs2.
        setin(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc_chk("lu_rs2", O_LOAD);
        idle();
        cyc_chk("lu_rs2_bubble", O_NONE);

        // No false hazards.
        setin(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc_chk("nofalse_x0", O_NONE);
        setin(5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc_chk("nofalse_rs2_unused", O_NONE);
        setin(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc_chk("nofalse_no_wb", O_NONE);
        setin(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc_chk("nofalse_not_load", O_NONE);

        // Branch overrides load-use and stays in RUN (next cycle detects again).
        setin(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc_chk("br_over_lu", O_BR);
        EX_Branch_Taken = 1'b0;
        cyc_chk("br_then_lu", O_LOAD);
        idle();
        cyc_chk("br_lu_bubble", O_NONE);
        EX_Branch_Taken = 1'b1;
        cyc_chk("br_alone", O_BR);
        idle();
        cyc_chk("br_done", O_NONE);

        // Single divide: 34 busy cycles, one release pulse, back to RUN.
        EX_Div_Start = 1'b1;
        div_seq("div1");
        idle();
        cyc_chk("div1_run", O_NONE);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_load", Load_Stall_Count, 32'd3);
        chk("perf_div", Div_Stall_Count, 32'd34);
        chk("perf_flush", Flush_Count, 32'd2);
`endif

        // Back-to-back divides: 34 + 1 + 34 + 1.
        EX_Div_Start = 1'b1;
        div_seq("b2b_a");
        div_seq("b2b_b");
        idle();
        cyc_chk("b2b_run", O_NONE);

        // Divide wins over an (illegal) simultaneous load-use match.
        setin(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc_chk("div_over_lu", O_DIV);
        setin(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 33; i++) cyc_chk("div_over_lu_busy", O_DIV);
        idle();
        cyc_chk("div_over_lu_rel", O_REL);

        // Branch wins over divide start in RUN.
        setin(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc_chk("br_over_div", O_BR);
        idle();
        cyc_chk("br_over_div_after", O_NONE);

        // Async reset in the middle of DIV_WAIT: abandon, no release pulse.
        EX_Div_Start = 1'b1;
        for (int i = 0; i < 11; i++) cyc_chk("rstdiv_busy", O_DIV);
        #2;
        reset = 1'b1;
        #1;
        chk("rstdiv_async", {24'd0, outv}, 32'd0);
        @(posedge clk); #1;
        idle();
        reset = 1'b0;
        for (int i = 0; i < 40; i++) cyc_chk("rstdiv_no_rel", O_NONE);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_rst_div", Div_Stall_Count, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline hazard controller for the 5-stage RV32IM core; sits beside the operand forwarding logic at the ID/EX boundary.
- Handles the hazards that forwarding cannot resolve:
  - load-use: inserts a one-cycle bubble, after which the load value is forwarded from MEM.
  - multi-cycle DIV/REM occupancy of EX: holds the pipeline for the divider latency.
  - taken-branch/jump redirect from EX: flushes the younger instructions.
- Drives stall/flush enables of PC, IF/ID, ID/EX and EX/MEM pipeline registers.

Parameters:
- RegAddrWidth, 5, register index width
- DivLatency, 34, total EX occupancy in cycles of a DIV/REM instruction (legal range 2..255)
- CntWidth, 8, width of internal divide-wait counter

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- ID_RS1  input  RegAddrWidth  rs1 index of instruction in ID
- ID_RS2  input  RegAddrWidth  rs2 index of instruction in ID
- ID_Uses_RS1  input  1  ID instruction reads rs1
- ID_Uses_RS2  input  1  ID instruction reads rs2
- EX_RD  input  RegAddrWidth  destination index of instruction in EX
- EX_Reg_File_EN  input  1  EX instruction writes register file
- EX_Mem_Read_EN  input  1  EX instruction is a load
- EX_Div_Start  input  1  EX instruction is DIV/DIVU/REM/REMU
- EX_Branch_Taken  input  1  EX resolved taken branch/jump (redirect)
- PC_Stall  output  1  hold PC
- IF_ID_Stall  output  1  hold IF/ID register
- IF_ID_Flush  output  1  clear IF/ID to NOP
- ID_EX_Stall  output  1  hold ID/EX register
- ID_EX_Flush  output  1  clear ID/EX to NOP (bubble)
- EX_MEM_Flush  output  1  clear EX/MEM to NOP
- Div_Busy  output  1  divider occupying EX
- Div_Result_Valid  output  1  one-cycle pulse: divider result valid in EX this cycle

Behaviour:
- Reset: async, active-high.
  - State forced to RUN, counter = 0.
  - All outputs 0 while reset is high and in the first cycle after release.
  - Reset mid-divide abandons the wait; no Div_Result_Valid pulse is produced.
- States: RUN, LOAD_BUBBLE, DIV_WAIT, DIV_RELEASE. Outputs are a combinational decode of state plus inputs (no added latency).
- Load-use hazard condition: EX_Mem_Read_EN & EX_Reg_File_EN & EX_RD != 0 & ((ID_Uses_RS1 & ID_RS1 == EX_RD) | (ID_Uses_RS2 & ID_RS2 == EX_RD)).
- RUN, priority high to low:
  1. EX_Branch_Taken: IF_ID_Flush = 1, ID_EX_Flush = 1; stays RUN. Load-use detection is ignored because the ID instruction is wrong-path.
  2. EX_Div_Start: PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Flush = 1 and Div_Busy = 1; counter <= DivLatency-2; next state DIV_WAIT. If EX_Mem_Read_EN is also set (illegal combination), the divide still wins.
  3. Load-use hazard: PC_Stall, IF_ID_Stall, ID_EX_Flush = 1; next state LOAD_BUBBLE.
  4. Otherwise all outputs 0.
- LOAD_BUBBLE: exactly one cycle.
  - EX holds the bubble, so detection is masked and all outputs are 0.
  - Next state RUN.
  - EX_Branch_Taken in this state is a protocol error and is ignored.
- DIV_WAIT:
  - Outputs asserted: PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Flush, Div_Busy.
  - If counter == 0, next state DIV_RELEASE; else counter decrements.
  - Total stalled cycles including the start cycle = DivLatency exactly.
- DIV_RELEASE: one cycle.
  - Div_Result_Valid = 1, all stalls 0.
  - EX_Div_Start is ignored because the same instruction is still in EX; it advances to MEM at the end of this cycle.
  - EX_Branch_Taken is ignored (a DIV is not a branch).
  - Next state RUN.
- A DIV/REM immediately following another DIV/REM (back-to-back) enters RUN and then restarts the sequence in that RUN cycle.
- Counter: unsigned, CntWidth bits, never wraps (guarded at 0). DivLatency-2 must fit in CntWidth; elaboration-time check.
- x0 is never a hazard source.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds the following outputs, each 32-bit, wrapping at 2^32, reset to 0:
  - Load_Stall_Count: +1 per load-use bubble.
  - Div_Stall_Count: +1 per cycle with Div_Busy.
  - Flush_Count: +1 per cycle with EX_Branch_Taken in RUN.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package buraq_hazard_pkg:
  - hazard_state_e enum (RUN, LOAD_BUBBLE, DIV_WAIT, DIV_RELEASE, 2-bit).
  - DIV_LATENCY_DEFAULT constant.
  - hazard_ctrl_t packed struct grouping the six stall/flush bits.
- Sub-module hazard_perf_counter (one 32-bit enabled wrapping counter), instantiated three times, only under HAZARD_PERF_CNT_EN.

Test Plan:
- Load-use: EX lw x5 (EX_Mem_Read_EN = 1, EX_RD = 5), ID add reading rs1 = 5 -> PC_Stall, IF_ID_Stall, ID_EX_Flush = 1 for exactly 1 cycle; next cycle all 0.
- No false hazard: EX_RD = 0 load with ID_RS1 = 0, or ID_Uses_RS2 = 0 with ID_RS2 = EX_RD = 7 -> all outputs 0.
- Divide, DivLatency = 34: EX_Div_Start held high -> stalls and Div_Busy high for exactly 34 cycles, then a 1-cycle Div_Result_Valid, then RUN; two back-to-back divides -> 34 + 1 + 34 + 1 pattern.
- Branch vs load-use: EX_Branch_Taken = 1 with a load-use match present -> IF_ID_Flush = ID_EX_Flush = 1, PC_Stall = 0, state stays RUN.
- Async reset asserted at cycle 10 of DIV_WAIT -> all outputs 0 immediately without a clock edge; after release, no Div_Result_Valid pulse appears.
- With HAZARD_PERF_CNT_EN: 3 load-use events + 1 divide (DivLatency = 34) + 2 flushes -> counters read 3 / 34 / 2.
